commit_trace_tx: RTL and testbench
==================================

Name: commit_trace_tx

Overview:
- In-core producer of retirement trace records, placed beside the ROB commit port.
- Per retiring instruction, assembles one complete record:
  - instruction, PC, register-file and PC writeback
  - memory access info captured per ROB tag at LSU completion
- Records are queued in a small FIFO and emitted one per cycle over a valid/ready interface to the RVFI/trace consumer.
- Replaces last-access memory snooping with exact per-instruction capture.

Parameters:
- TAG_W, 5, ROB tag width; mem-info table has 2**TAG_W entries.
- FIFO_DEPTH, 4, outgoing record queue depth; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- commit_valid  in  1  ROB head retiring this cycle
- commit_tag  in  TAG_W  ROB tag of retiring entry
- commit_inst  in  32  instruction word
- commit_pc  in  32  instruction PC
- commit_rs1_rdata  in  32  rs1 operand value
- commit_rs2_rdata  in  32  rs2 operand value
- commit_rd_wdata  in  32  rd writeback value
- flush  in  1  redirect caused by the retiring instruction
- pc_new  in  32  redirect target; valid with flush
- lsu_done  in  1  LSU completed an access
- lsu_tag  in  TAG_W  ROB tag of that access
- lsu_addr  in  32  access address
- lsu_rmask  in  4  read mask
- lsu_wmask  in  4  write mask
- lsu_rdata  in  32  raw read data
- lsu_wdata  in  32  write data
- commit_stall  out  1  FIFO full; ROB must hold retirement
- tr_valid  out  1  record available
- tr_ready  in  1  consumer accepts record
- tr_order  out  64  retirement sequence number
- tr_inst, tr_pc_rdata, tr_pc_wdata, tr_rs1_rdata, tr_rs2_rdata, tr_rd_wdata, tr_mem_addr, tr_mem_rdata, tr_mem_wdata  out  32 each  record fields
- tr_rs1_addr, tr_rs2_addr, tr_rd_addr  out  5 each  record register indices
- tr_mem_rmask, tr_mem_wmask  out  4 each  record memory masks
- overflow  out  1  sticky: record lost

Behaviour:
- Reset (async): FIFO empty, order=0, all mem-table valid bits 0. Outputs on reset: tr_valid=0, overflow=0, commit_stall=0.
- Mem table:
  - On lsu_done, write addr/masks/wdata/rdata at lsu_tag and set its valid bit.
  - A later write to the same tag overwrites.
- Record build, combinational from commit inputs:
  - rs1_addr is nonzero only for jalr/br/load/store/imm/reg.
  - rs2_addr is nonzero only for br/store/reg.
  - rd_addr=0 for store/br.
  - rsN_rdata is forced to 0 when rsN_addr==0.
  - pc_wdata = flush ? pc_new : pc+4.
  - Mem fields come from table[commit_tag] if its valid bit is set, else all zero.
  - mem_rdata is masked by rmask, byte-wise.
- Push condition: commit_valid && (!full || (tr_valid && tr_ready)).
  - On push: the record gets order = current counter; counter increments; table[commit_tag] valid bit is cleared.
- commit_valid while full with no pop: record dropped, overflow sets and holds until reset, counter unchanged.
- commit_stall = full. It is driven from registered pointers only; there is no tr_ready path.
- Flush:
  - Same cycle as commit: record is pushed first.
  - Then every mem-table valid bit clears; squashed younger loads/stores leave no stale info.
  - FIFO contents are not affected.
- Simultaneous lsu_done and commit on the same tag: the commit sees the incoming LSU data (write-through forwarding); the table entry ends invalid.
- FIFO pointers are PTR_W+1 bits wide with a wrap bit.
  - empty when pointers are equal.
  - full when indices are equal and wrap bits differ.
  - Push and pop in the same cycle while full is legal.
- Latency: push in cycle N → tr_valid in cycle N+1.
- Output fields are held stable while tr_valid && !tr_ready.

Optional Feature:
- COMMIT_TRACE_BYPASS_EN:
  - Defined: when the FIFO is empty and tr_ready=1, a commit is presented on tr_* in the same cycle (tr_valid=commit_valid) and is not enqueued. Latency 0.
  - Undefined: always registered, latency 1.

Decomposition:
- rv32i_types package: opcode constants (op_b_*), load_f3_* constants, a packed trace_rec_t struct (all tr_* fields), and a mem_info_t struct.
- One sub-module: trace_fifo (parameterised packed-struct FIFO, valid/ready out, full/empty flags).

Test Plan:
- Back-to-back ALU commits, tr_ready=1: addi x1,x0,5 at pc 0x6000_0000 → tr_order 0, rd=1, rd_wdata=5, rs1_addr=0, rs1_rdata=0, pc_wdata=0x6000_0004, mem fields 0.
- Load lb: lsu_done tag 3, addr 0x100, rmask 0x2, rdata 0xAABBCCDD; commit tag 3 two cycles later → mem_addr 0x100, rmask 0x2, mem_rdata 0x0000CC00; table[3] invalid afterwards.
- Backpressure with FIFO_DEPTH=4: tr_ready=0 with 4 commits → commit_stall=1. A 5th commit_valid → overflow=1. Raise tr_ready → orders 0..3 drain in order.
- Flush with taken branch at 0x60000010, target 0x60000100 → pc_wdata 0x60000100. An entry previously written for a younger tag is invalid; a subsequent commit on that tag shows zero mem fields.
- Same-cycle lsu_done and commit, tag 7, sw wmask 0xF wdata 0x1234 → record carries the forwarded values.
- Async rst asserted mid-drain, between clock edges → tr_valid=0 immediately; next record after reset has order 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I decode constants and trace record types for the commit trace producer.
package rv32i_types;

   localparam logic [6:0] op_b_lui   = 7'b0110111;
   localparam logic [6:0] op_b_auipc = 7'b0010111;
   localparam logic [6:0] op_b_jal   = 7'b1101111;
   localparam logic [6:0] op_b_jalr  = 7'b1100111;
   localparam logic [6:0] op_b_br    = 7'b1100011;
   localparam logic [6:0] op_b_load  = 7'b0000011;
   localparam logic [6:0] op_b_store = 7'b0100011;
   localparam logic [6:0] op_b_imm   = 7'b0010011;
   localparam logic [6:0] op_b_reg   = 7'b0110011;

   localparam logic [2:0] load_f3_lb  = 3'b000;
   localparam logic [2:0] load_f3_lh  = 3'b001;
   localparam logic [2:0] load_f3_lw  = 3'b010;
   localparam logic [2:0] load_f3_lbu = 3'b100;
   localparam logic [2:0] load_f3_lhu = 3'b101;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic [31:0] rdata;
      logic [31:0] wdata;
   } mem_info_t;

   typedef struct packed {
      logic [63:0] order;
      logic [31:0] inst;
      logic [31:0] pc_rdata;
      logic [31:0] pc_wdata;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic [31:0] rs1_rdata;
      logic [31:0] rs2_rdata;
      logic [31:0] rd_wdata;
      logic [31:0] mem_addr;
      logic [3:0]  mem_rmask;
      logic [3:0]  mem_wmask;
      logic [31:0] mem_rdata;
      logic [31:0] mem_wdata;
   } trace_rec_t;

   function automatic logic [31:0] byte_mask(input logic [31:0] data, input logic [3:0] mask);
      return data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
   endfunction

endpackage

// File: rtl/commit_trace_tx_if.sv
// Valid/ready trace record bus from the commit trace producer to the RVFI/trace consumer.
interface commit_trace_tx_if;

   logic        tr_valid;
   logic        tr_ready;
   logic [63:0] tr_order;
   logic [31:0] tr_inst;
   logic [31:0] tr_pc_rdata;
   logic [31:0] tr_pc_wdata;
   logic [4:0]  tr_rs1_addr;
   logic [4:0]  tr_rs2_addr;
   logic [4:0]  tr_rd_addr;
   logic [31:0] tr_rs1_rdata;
   logic [31:0] tr_rs2_rdata;
   logic [31:0] tr_rd_wdata;
   logic [31:0] tr_mem_addr;
   logic [3:0]  tr_mem_rmask;
   logic [3:0]  tr_mem_wmask;
   logic [31:0] tr_mem_rdata;
   logic [31:0] tr_mem_wdata;

   modport master (
      output tr_valid, tr_order, tr_inst, tr_pc_rdata, tr_pc_wdata,
             tr_rs1_addr, tr_rs2_addr, tr_rd_addr, tr_rs1_rdata, tr_rs2_rdata, tr_rd_wdata,
             tr_mem_addr, tr_mem_rmask, tr_mem_wmask, tr_mem_rdata, tr_mem_wdata,
      input  tr_ready
   );

   modport slave (
      input  tr_valid, tr_order, tr_inst, tr_pc_rdata, tr_pc_wdata,
             tr_rs1_addr, tr_rs2_addr, tr_rd_addr, tr_rs1_rdata, tr_rs2_rdata, tr_rd_wdata,
             tr_mem_addr, tr_mem_rmask, tr_mem_wmask, tr_mem_rdata, tr_mem_wdata,
      output tr_ready
   );

endinterface

// File: rtl/trace_fifo.sv
// Parameterised FIFO of packed records; wrap-bit pointers give exact full/empty.
module trace_fifo #(
   parameter type T     = logic,
   parameter int  DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output logic valid_o,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   logic           do_push, do_pop;
   T               mem_q [DEPTH];

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                    (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
   assign valid_o = !empty_o;
   assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

   // A push into a full queue is legal only when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone decide which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
   end

endmodule

// File: rtl/commit_trace_tx.sv
// Retirement trace producer: builds one record per commit with exact per-tag memory info.
// Optional macro COMMIT_TRACE_BYPASS_EN presents a commit directly when the queue is empty.
module commit_trace_tx
   import rv32i_types::*;
#(
   parameter int TAG_W      = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             commit_valid,
   input  logic [TAG_W-1:0] commit_tag,
   input  logic [31:0]      commit_inst,
   input  logic [31:0]      commit_pc,
   input  logic [31:0]      commit_rs1_rdata,
   input  logic [31:0]      commit_rs2_rdata,
   input  logic [31:0]      commit_rd_wdata,
   input  logic             flush,
   input  logic [31:0]      pc_new,
   input  logic             lsu_done,
   input  logic [TAG_W-1:0] lsu_tag,
   input  logic [31:0]      lsu_addr,
   input  logic [3:0]       lsu_rmask,
   input  logic [3:0]       lsu_wmask,
   input  logic [31:0]      lsu_rdata,
   input  logic [31:0]      lsu_wdata,
   output logic             commit_stall,
   output logic             overflow,
   commit_trace_tx_if.master tr
);

   localparam int TBL_N = 1 << TAG_W;

   mem_info_t        mem_tbl_q [TBL_N];
   logic [TBL_N-1:0] tbl_vld_q, tbl_vld_d;
   logic [63:0]      order_q, order_d;
   logic             overflow_q, overflow_d;

   mem_info_t  lsu_info, mem_sel;
   trace_rec_t rec, fifo_rec, out_rec;
   logic [6:0] opcode;
   logic       uses_rs1, uses_rs2, no_rd;
   logic       fifo_full, fifo_empty, fifo_valid, fifo_pop;
   logic       accept, bypass, out_vld;

   assign lsu_info = '{addr: lsu_addr, rmask: lsu_rmask, wmask: lsu_wmask,
                       rdata: lsu_rdata, wdata: lsu_wdata};

   assign opcode   = commit_inst[6:0];
   assign uses_rs1 = opcode inside {op_b_jalr, op_b_br, op_b_load, op_b_store, op_b_imm, op_b_reg};
   assign uses_rs2 = opcode inside {op_b_br, op_b_store, op_b_reg};
   assign no_rd    = opcode inside {op_b_store, op_b_br};

   // An LSU completion landing on the retiring tag this cycle is forwarded past the table.
   always_comb begin
      mem_sel = '0;
      if (lsu_done && (lsu_tag == commit_tag)) mem_sel = lsu_info;
      else if (tbl_vld_q[commit_tag])          mem_sel = mem_tbl_q[commit_tag];
   end

   always_comb begin
      rec           = '0;
      rec.order     = order_q;
      rec.inst      = commit_inst;
      rec.pc_rdata  = commit_pc;
      rec.pc_wdata  = flush ? pc_new : commit_pc + 32'd4;
      rec.rs1_addr  = uses_rs1 ? commit_inst[19:15] : 5'd0;
      rec.rs2_addr  = uses_rs2 ? commit_inst[24:20] : 5'd0;
      rec.rd_addr   = no_rd ? 5'd0 : commit_inst[11:7];
      rec.rs1_rdata = (rec.rs1_addr == 5'd0) ? 32'd0 : commit_rs1_rdata;
      rec.rs2_rdata = (rec.rs2_addr == 5'd0) ? 32'd0 : commit_rs2_rdata;
      rec.rd_wdata  = commit_rd_wdata;
      rec.mem_addr  = mem_sel.addr;
      rec.mem_rmask = mem_sel.rmask;
      rec.mem_wmask = mem_sel.wmask;
      rec.mem_rdata = byte_mask(mem_sel.rdata, mem_sel.rmask);
      rec.mem_wdata = mem_sel.wdata;
   end

   assign fifo_pop = tr.tr_ready && !fifo_empty;
   assign accept   = commit_valid && (!fifo_full || fifo_pop);

`ifdef COMMIT_TRACE_BYPASS_EN
   assign bypass  = fifo_empty && tr.tr_ready;
   assign out_rec = bypass ? rec : fifo_rec;
   assign out_vld = bypass ? commit_valid : fifo_valid;
`else
   assign bypass  = 1'b0;
   assign out_rec = fifo_rec;
   assign out_vld = fifo_valid;
`endif

   trace_fifo #(
      .T     (trace_rec_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (accept && !bypass),
      .data_i  (rec),
      .pop_i   (fifo_pop),
      .valid_o (fifo_valid),
      .data_o  (fifo_rec),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Flush is applied last: the retiring record has already sampled the table this cycle.
   always_comb begin
      tbl_vld_d  = tbl_vld_q;
      order_d    = order_q;
      overflow_d = overflow_q;
      if (lsu_done) tbl_vld_d[lsu_tag] = 1'b1;
      if (accept) begin
         order_d               = order_q + 64'd1;
         tbl_vld_d[commit_tag] = 1'b0;
      end
      if (commit_valid && !accept) overflow_d = 1'b1;
      if (flush) tbl_vld_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tbl_vld_q  <= '0;
         order_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         tbl_vld_q  <= tbl_vld_d;
         order_q    <= order_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (lsu_done) mem_tbl_q[lsu_tag] <= lsu_info;
   end

   assign commit_stall    = fifo_full;
   assign overflow        = overflow_q;

   assign tr.tr_valid     = out_vld;
   assign tr.tr_order     = out_rec.order;
   assign tr.tr_inst      = out_rec.inst;
   assign tr.tr_pc_rdata  = out_rec.pc_rdata;
   assign tr.tr_pc_wdata  = out_rec.pc_wdata;
   assign tr.tr_rs1_addr  = out_rec.rs1_addr;
   assign tr.tr_rs2_addr  = out_rec.rs2_addr;
   assign tr.tr_rd_addr   = out_rec.rd_addr;
   assign tr.tr_rs1_rdata = out_rec.rs1_rdata;
   assign tr.tr_rs2_rdata = out_rec.rs2_rdata;
   assign tr.tr_rd_wdata  = out_rec.rd_wdata;
   assign tr.tr_mem_addr  = out_rec.mem_addr;
   assign tr.tr_mem_rmask = out_rec.mem_rmask;
   assign tr.tr_mem_wmask = out_rec.mem_wmask;
   assign tr.tr_mem_rdata = out_rec.mem_rdata;
   assign tr.tr_mem_wdata = out_rec.mem_wdata;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Scoreboard bench for commit_trace_tx: directed commits push expected records, a monitor pops and compares.
`timescale 1ns/1ps
module tb_commit_trace_tx;
   import rv32i_types::*;

   localparam int TAG_W = 5;

   localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5
   localparam logic [31:0] I_ADD  = 32'h0020_81B3;  // add  x3,x1,x2
   localparam logic [31:0] I_LB   = 32'h0003_0283;  // lb   x5,0(x6)
   localparam logic [31:0] I_BEQ  = 32'h0020_8463;  // beq  x1,x2 (rd field nonzero)
   localparam logic [31:0] I_SW   = 32'h0020_A023;  // sw   x2,0(x1)

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             commit_valid = 1'b0;
   logic [TAG_W-1:0] commit_tag = '0;
   logic [31:0]      commit_inst = '0, commit_pc = '0;
   logic [31:0]      commit_rs1_rdata = '0, commit_rs2_rdata = '0, commit_rd_wdata = '0;
   logic             flush = 1'b0;
   logic [31:0]      pc_new = '0;
   logic             lsu_done = 1'b0;
   logic [TAG_W-1:0] lsu_tag = '0;
   logic [31:0]      lsu_addr = '0, lsu_rdata = '0, lsu_wdata = '0;
   logic [3:0]       lsu_rmask = '0, lsu_wmask = '0;
   logic             commit_stall, overflow;

   commit_trace_tx_if tr_if ();

   commit_trace_tx #(.TAG_W(TAG_W), .FIFO_DEPTH(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .commit_valid     (commit_valid),
      .commit_tag       (commit_tag),
      .commit_inst      (commit_inst),
      .commit_pc        (commit_pc),
      .commit_rs1_rdata (commit_rs1_rdata),
      .commit_rs2_rdata (commit_rs2_rdata),
      .commit_rd_wdata  (commit_rd_wdata),
      .flush            (flush),
      .pc_new           (pc_new),
      .lsu_done         (lsu_done),
      .lsu_tag          (lsu_tag),
      .lsu_addr         (lsu_addr),
      .lsu_rmask        (lsu_rmask),
      .lsu_wmask        (lsu_wmask),
      .lsu_rdata        (lsu_rdata),
      .lsu_wdata        (lsu_wdata),
      .commit_stall     (commit_stall),
      .overflow         (overflow),
      .tr               (tr_if)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   trace_rec_t  exp_q[$];
   logic [63:0] exp_order = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic mem_info_t mi(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                                    input logic [31:0] rd, input logic [31:0] wd);
      return '{addr: addr, rmask: rm, wmask: wm, rdata: rd, wdata: wd};
   endfunction

   function automatic trace_rec_t mk(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] pcw,
                                     input logic [4:0] rs1a, input logic [4:0] rs2a, input logic [4:0] rda,
                                     input logic [31:0] rs1d, input logic [31:0] rs2d, input logic [31:0] rdd,
                                     input mem_info_t m);
      trace_rec_t r;
      r           = '0;
      r.inst      = inst;
      r.pc_rdata  = pc;
      r.pc_wdata  = pcw;
      r.rs1_addr  = rs1a;
      r.rs2_addr  = rs2a;
      r.rd_addr   = rda;
      r.rs1_rdata = rs1d;
      r.rs2_rdata = rs2d;
      r.rd_wdata  = rdd;
      r.mem_addr  = m.addr;
      r.mem_rmask = m.rmask;
      r.mem_wmask = m.wmask;
      r.mem_rdata = m.rdata;
      r.mem_wdata = m.wdata;
      return r;
   endfunction

   task automatic push_exp(input trace_rec_t r);
      r.order = exp_order;
      exp_order++;
      exp_q.push_back(r);
   endtask

   task automatic cmp_rec(input trace_rec_t e);
      string p;
      p = $sformatf("rec%0d", e.order);
      check({p, ".order"},     tr_if.tr_order,              e.order);
      check({p, ".inst"},      64'(tr_if.tr_inst),          64'(e.inst));
      check({p, ".pc_rdata"},  64'(tr_if.tr_pc_rdata),      64'(e.pc_rdata));
      check({p, ".pc_wdata"},  64'(tr_if.tr_pc_wdata),      64'(e.pc_wdata));
      check({p, ".rs1_addr"},  64'(tr_if.tr_rs1_addr),      64'(e.rs1_addr));
      check({p, ".rs2_addr"},  64'(tr_if.tr_rs2_addr),      64'(e.rs2_addr));
      check({p, ".rd_addr"},   64'(tr_if.tr_rd_addr),       64'(e.rd_addr));
      check({p, ".rs1_rdata"}, 64'(tr_if.tr_rs1_rdata),     64'(e.rs1_rdata));
      check({p, ".rs2_rdata"}, 64'(tr_if.tr_rs2_rdata),     64'(e.rs2_rdata));
      check({p, ".rd_wdata"},  64'(tr_if.tr_rd_wdata),      64'(e.rd_wdata));
      check({p, ".mem_addr"},  64'(tr_if.tr_mem_addr),      64'(e.mem_addr));
      check({p, ".mem_rmask"}, 64'(tr_if.tr_mem_rmask),     64'(e.mem_rmask));
      check({p, ".mem_wmask"}, 64'(tr_if.tr_mem_wmask),     64'(e.mem_wmask));
      check({p, ".mem_rdata"}, 64'(tr_if.tr_mem_rdata),     64'(e.mem_rdata));
      check({p, ".mem_wdata"}, 64'(tr_if.tr_mem_wdata),     64'(e.mem_wdata));
   endtask

   // Monitor: every accepted output beat is compared against the oldest expected record.
   always @(negedge clk) begin
      if (!rst && tr_if.tr_valid && tr_if.tr_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_record: got order %0d expected no record", tr_if.tr_order);
         end else begin
            cmp_rec(exp_q.pop_front());
         end
      end
   end

   task automatic do_commit(input logic [TAG_W-1:0] tag, input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] rs1d, input logic [31:0] rs2d, input logic [31:0] rdd,
                            input logic fl, input logic [31:0] pnew);
      commit_valid     = 1'b1;
      commit_tag       = tag;
      commit_inst      = inst;
      commit_pc        = pc;
      commit_rs1_rdata = rs1d;
      commit_rs2_rdata = rs2d;
      commit_rd_wdata  = rdd;
      flush            = fl;
      pc_new           = pnew;
      @(posedge clk);
      #1;
      commit_valid = 1'b0;
      flush        = 1'b0;
   endtask

   task automatic do_lsu(input logic [TAG_W-1:0] tag, input mem_info_t m);
      lsu_done  = 1'b1;
      lsu_tag   = tag;
      lsu_addr  = m.addr;
      lsu_rmask = m.rmask;
      lsu_wmask = m.wmask;
      lsu_rdata = m.rdata;
      lsu_wdata = m.wdata;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      exp_q.delete();
      exp_order = '0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tr_if.tr_ready = 1'b1;
      #2;
      check("reset_tr_valid",     64'(tr_if.tr_valid), 64'd0);
      check("reset_overflow",     64'(overflow),       64'd0);
      check("reset_commit_stall", 64'(commit_stall),   64'd0);
      apply_reset();

      // Back-to-back ALU commits with the consumer always ready.
      push_exp(mk(I_ADDI, 32'h6000_0000, 32'h6000_0004, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd5, '0));
      check("pre_push_tr_valid", 64'(tr_if.tr_valid), 64'd0);
      do_commit(5'd0, I_ADDI, 32'h6000_0000, 32'hDEAD_BEEF, 32'h0000_1111, 32'd5, 1'b0, '0);
      check("latency_n_plus_1", 64'(tr_if.tr_valid), 64'd1);
      push_exp(mk(I_ADD, 32'h6000_0004, 32'h6000_0008, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd12, '0));
      do_commit(5'd1, I_ADD, 32'h6000_0004, 32'd5, 32'd7, 32'd12, 1'b0, '0);

      // lb on tag 3: completion recorded, then consumed two cycles later, then the entry is gone.
      do_lsu(5'd3, mi(32'h100, 4'h2, 4'h0, 32'hAABB_CCDD, 32'h0));
      @(posedge clk);
      #1;
      lsu_done = 1'b0;
      @(posedge clk);
      #1;
      push_exp(mk(I_LB, 32'h6000_0008, 32'h6000_000C, 5'd6, 5'd0, 5'd5, 32'h100, 32'd0, 32'hFFFF_FFCC,
                  mi(32'h100, 4'h2, 4'h0, 32'h0000_CC00, 32'h0)));
      do_commit(5'd3, I_LB, 32'h6000_0008, 32'h100, 32'h77, 32'hFFFF_FFCC, 1'b0, '0);
      push_exp(mk(I_ADDI, 32'h6000_000C, 32'h6000_0010, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd5, '0));
      do_commit(5'd3, I_ADDI, 32'h6000_000C, 32'd0, 32'd0, 32'd5, 1'b0, '0);

      // Younger store completes, then an older taken branch flushes: the store's info must vanish.
      do_lsu(5'd9, mi(32'h300, 4'h0, 4'hF, 32'h0, 32'hAB));
      @(posedge clk);
      #1;
      lsu_done = 1'b0;
      push_exp(mk(I_BEQ, 32'h6000_0010, 32'h6000_0100, 5'd1, 5'd2, 5'd0, 32'd3, 32'd3, 32'h99, '0));
      do_commit(5'd8, I_BEQ, 32'h6000_0010, 32'd3, 32'd3, 32'h99, 1'b1, 32'h6000_0100);
      push_exp(mk(I_SW, 32'h6000_0100, 32'h6000_0104, 5'd1, 5'd2, 5'd0, 32'h300, 32'hAB, 32'd0, '0));
      do_commit(5'd9, I_SW, 32'h6000_0100, 32'h300, 32'hAB, 32'd0, 1'b0, '0);

      // Same-cycle LSU completion and commit on tag 7 forwards the incoming data.
      do_lsu(5'd7, mi(32'h200, 4'h0, 4'hF, 32'h0, 32'h1234));
      push_exp(mk(I_SW, 32'h6000_0104, 32'h6000_0108, 5'd1, 5'd2, 5'd0, 32'h200, 32'h1234, 32'd0,
                  mi(32'h200, 4'h0, 4'hF, 32'h0, 32'h1234)));
      do_commit(5'd7, I_SW, 32'h6000_0104, 32'h200, 32'h1234, 32'd0, 1'b0, '0);
      lsu_done = 1'b0;
      push_exp(mk(I_ADDI, 32'h6000_0108, 32'h6000_010C, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd5, '0));
      do_commit(5'd7, I_ADDI, 32'h6000_0108, 32'd0, 32'd0, 32'd5, 1'b0, '0);
      drain("drain_basic");

      // Backpressure: fill, overflow on a fifth commit, then push+pop while full.
      apply_reset();
      tr_if.tr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push_exp(mk(I_ADDI, 32'h6000_0200 + 32'(4 * i), 32'h6000_0204 + 32'(4 * i),
                     5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'(i), '0));
         do_commit(5'(i), I_ADDI, 32'h6000_0200 + 32'(4 * i), 32'd0, 32'd0, 32'(i), 1'b0, '0);
      end
      check("full_commit_stall", 64'(commit_stall), 64'd1);
      check("full_no_overflow",  64'(overflow),     64'd0);
      do_commit(5'd4, I_ADDI, 32'h6000_0210, 32'd0, 32'd0, 32'd99, 1'b0, '0);
      check("drop_overflow",     64'(overflow),        64'd1);
      check("drop_head_order",   tr_if.tr_order,       64'd0);
      check("drop_head_valid",   64'(tr_if.tr_valid),  64'd1);
      tr_if.tr_ready = 1'b1;
      push_exp(mk(I_ADDI, 32'h6000_0214, 32'h6000_0218, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd4, '0));
      do_commit(5'd5, I_ADDI, 32'h6000_0214, 32'd0, 32'd0, 32'd4, 1'b0, '0);
      check("push_pop_full_stall", 64'(commit_stall), 64'd1);
      drain("drain_backpressure");
      check("overflow_sticky",    64'(overflow),       64'd1);
      check("drained_stall",      64'(commit_stall),   64'd0);
      check("drained_tr_valid",   64'(tr_if.tr_valid), 64'd0);

      // Asynchronous reset between edges while records are still queued.
      tr_if.tr_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         push_exp(mk(I_ADDI, 32'h6000_0300 + 32'(4 * i), 32'h6000_0304 + 32'(4 * i),
                     5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'(i), '0));
         do_commit(5'(i), I_ADDI, 32'h6000_0300 + 32'(4 * i), 32'd0, 32'd0, 32'(i), 1'b0, '0);
      end
      tr_if.tr_ready = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_tr_valid", 64'(tr_if.tr_valid), 64'd0);
      check("async_rst_overflow", 64'(overflow),       64'd0);
      check("async_rst_stall",    64'(commit_stall),   64'd0);
      exp_q.delete();
      exp_order = '0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      push_exp(mk(I_ADD, 32'h6000_0400, 32'h6000_0404, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd3, '0));
      do_commit(5'd2, I_ADD, 32'h6000_0400, 32'd1, 32'd2, 32'd3, 1'b0, '0);
      drain("drain_after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
